// File: rtl/uninasoc_pkg.sv
// Shared SoC constants: default interrupt source count and the register map of
// the platform interrupt controller.
package uninasoc_pkg;

    localparam int NUM_IRQ   = 3;
    localparam int IRQC_ID_W = 5;

    localparam logic [7:0] IRQC_PENDING_OFF = 8'h00;
    localparam logic [7:0] IRQC_ENABLE_OFF  = 8'h04;
    localparam logic [7:0] IRQC_EDGE_OFF    = 8'h08;
    localparam logic [7:0] IRQC_THRESH_OFF  = 8'h0C;
    localparam logic [7:0] IRQC_CLAIM_OFF   = 8'h10;
    localparam logic [7:0] IRQC_PRIO_BASE   = 8'h20;

endpackage

// File: rtl/uninasoc_irq_ctrl_if.sv
// Register access port of the interrupt controller: single-cycle req with an
// ack (and read data) returned exactly one cycle later.
interface uninasoc_irq_ctrl_if;

    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);

    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);

endinterface

// File: rtl/uninasoc_irq_arbiter.sv
// Combinational pick of the highest-priority candidate, lowest ID on ties,
// qualified against the priority threshold.
module uninasoc_irq_arbiter #(
    parameter int NUM_IRQ = 3,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_IRQ-1:0]                    cand,
    input  logic [NUM_IRQ-1:0][PRIO_W-1:0]        prio,
    input  logic [PRIO_W-1:0]                     threshold,
    output logic [uninasoc_pkg::IRQC_ID_W-1:0]    id,
    output logic                                  valid
);
    import uninasoc_pkg::*;

    logic [PRIO_W-1:0]    best_prio;
    logic [IRQC_ID_W-1:0] best_id;

    // Strict greater-than keeps the earliest (lowest) ID on ties and never
    // selects a priority-0 source.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = IRQC_ID_W'(i + 1);
            end
        end
        valid = (best_prio > threshold);
        id    = valid ? best_id : '0;
    end

endmodule

// File: rtl/uninasoc_irq_ctrl.sv
// Platform interrupt controller: gateways, enable/priority/threshold registers
// and claim/complete. Define UNINASOC_IRQ_SYNC_EN to add 2-flop input synchronisers.
module uninasoc_irq_ctrl #(
    parameter int NUM_IRQ = uninasoc_pkg::NUM_IRQ,
    parameter int PRIO_W  = 3,
    parameter int DATA_W  = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_IRQ-1:0]                    irq_src_i,
    uninasoc_irq_ctrl_if.slave                    bus,
    output logic                                  irq_o,
    output logic [uninasoc_pkg::IRQC_ID_W-1:0]    irq_id_o
);
    import uninasoc_pkg::*;

    logic [NUM_IRQ-1:0]             src_cond, src_prev, gate_set;
    logic [NUM_IRQ-1:0]             pending, in_service, enable, edge_mode;
    logic [NUM_IRQ-1:0]             claim_mask, complete_mask;
    logic [PRIO_W-1:0]              threshold;
    logic [NUM_IRQ-1:0][PRIO_W-1:0] prio;
    logic [IRQC_ID_W-1:0]           arb_id;
    logic                           arb_valid;
    logic                           wr, rd, claim_rd, complete_wr, prio_hit;
    logic [5:0]                     prio_idx;
    logic [DATA_W-1:0]              rd_mux;

`ifdef UNINASOC_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_cond = sync_q2;
`else
    assign src_cond = irq_src_i;
`endif

    assign wr          = bus.req & bus.we;
    assign rd          = bus.req & ~bus.we;
    assign claim_rd    = rd & (bus.addr == IRQC_CLAIM_OFF);
    assign complete_wr = wr & (bus.addr == IRQC_CLAIM_OFF);
    assign prio_idx    = bus.addr[7:2] - 6'd8;
    assign prio_hit    = (bus.addr[1:0] == 2'b00) && (bus.addr >= IRQC_PRIO_BASE)
                         && (int'(prio_idx) < NUM_IRQ);

    // A source in service latches nothing, so edges seen meanwhile are lost.
    assign gate_set = ~in_service & ((edge_mode & src_cond & ~src_prev) |
                                     (~edge_mode & src_cond));

    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            claim_mask[i]    = claim_rd && (irq_id_o == IRQC_ID_W'(i + 1));
            complete_mask[i] = complete_wr && (bus.wdata == 32'(i + 1));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            IRQC_PENDING_OFF: rd_mux[NUM_IRQ-1:0]   = pending;
            IRQC_ENABLE_OFF:  rd_mux[NUM_IRQ-1:0]   = enable;
            IRQC_EDGE_OFF:    rd_mux[NUM_IRQ-1:0]   = edge_mode;
            IRQC_THRESH_OFF:  rd_mux[PRIO_W-1:0]    = threshold;
            IRQC_CLAIM_OFF:   rd_mux[IRQC_ID_W-1:0] = irq_id_o;
            default: begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (prio_hit && (prio_idx == 6'(i))) rd_mux[PRIO_W-1:0] = prio[i];
                end
            end
        endcase
    end

    // The ID being claimed is masked here so the next registered candidate
    // already excludes it, allowing back-to-back claims.
    uninasoc_irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .PRIO_W  (PRIO_W)
    ) u_arbiter (
        .cand      (pending & enable & ~claim_mask),
        .prio      (prio),
        .threshold (threshold),
        .id        (arb_id),
        .valid     (arb_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
            enable     <= '0;
            edge_mode  <= '0;
            threshold  <= '0;
            prio       <= '0;
            irq_o      <= 1'b0;
            irq_id_o   <= '0;
            bus.ack    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            src_prev   <= src_cond;
            pending    <= (pending | gate_set) & ~claim_mask;
            in_service <= (in_service | claim_mask) & ~complete_mask;
            irq_o      <= arb_valid;
            irq_id_o   <= arb_id;
            bus.ack    <= bus.req;
            bus.rdata  <= rd ? rd_mux : '0;
            if (wr && (bus.addr == IRQC_ENABLE_OFF)) enable    <= bus.wdata[NUM_IRQ-1:0];
            if (wr && (bus.addr == IRQC_EDGE_OFF))   edge_mode <= bus.wdata[NUM_IRQ-1:0];
            if (wr && (bus.addr == IRQC_THRESH_OFF)) threshold <= bus.wdata[PRIO_W-1:0];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (wr && prio_hit && (prio_idx == 6'(i))) prio[i] <= bus.wdata[PRIO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_uninasoc_irq_ctrl.sv
// Directed self-checking bench for uninasoc_irq_ctrl (default build, NUM_IRQ=3).
module tb_uninasoc_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  irq_src;
    logic        irq;
    logic [4:0]  irq_id;
    logic [31:0] rd;
    int          checks;
    int          failures;

    uninasoc_irq_ctrl_if bus ();

    uninasoc_irq_ctrl #(
        .NUM_IRQ (3),
        .PRIO_W  (3),
        .DATA_W  (32)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .irq_src_i (irq_src),
        .bus       (bus.slave),
        .irq_o     (irq),
        .irq_id_o  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One register access; returns 1 ns after the edge that sampled req.
    task automatic applyStimulus(input logic w, input logic [7:0] a,
                                 input logic [31:0] d, output logic [31:0] r);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        r = bus.rdata;
        checkOutput("ack", {31'b0, bus.ack}, 32'h1);
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic pulseSrc(input logic [2:0] m);
        irq_src = m;
        @(posedge clk);
        #1;
        irq_src = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        irq_src   = '0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #3;
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_id", {27'b0, irq_id}, 32'h0);
        checkOutput("rst_ack", {31'b0, bus.ack}, 32'h0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        #20 rst_n = 1'b1;
        idle(1);

        // Edge-triggered single source
        applyStimulus(1, 8'h20, 32'd2, rd);
        applyStimulus(1, 8'h04, 32'h1, rd);
        applyStimulus(1, 8'h08, 32'h1, rd);
        applyStimulus(1, 8'h0C, 32'h0, rd);
        applyStimulus(0, 8'h20, 32'h0, rd);
        checkOutput("prio0_rb", rd, 32'd2);
        pulseSrc(3'b001);
        idle(1);
        checkOutput("edge_irq", {31'b0, irq}, 32'h1);
        checkOutput("edge_id", {27'b0, irq_id}, 32'd1);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("edge_pending", rd, 32'h1);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim1", rd, 32'd1);
        idle(1);
        checkOutput("after_claim_irq", {31'b0, irq}, 32'h0);
        pulseSrc(3'b001);
        idle(2);
        checkOutput("in_service_drop_irq", {31'b0, irq}, 32'h0);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("in_service_drop_pend", rd, 32'h0);
        applyStimulus(1, 8'h10, 32'd1, rd);
        pulseSrc(3'b001);
        idle(1);
        checkOutput("reassert_irq", {31'b0, irq}, 32'h1);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim1_again", rd, 32'd1);
        applyStimulus(1, 8'h10, 32'd1, rd);

        // Priorities {3,5,5}: claims in order 2, 3, 1, then none
        applyStimulus(1, 8'h20, 32'd3, rd);
        applyStimulus(1, 8'h24, 32'd5, rd);
        applyStimulus(1, 8'h28, 32'd5, rd);
        applyStimulus(1, 8'h04, 32'h7, rd);
        applyStimulus(1, 8'h08, 32'h7, rd);
        pulseSrc(3'b111);
        idle(1);
        checkOutput("tie_id", {27'b0, irq_id}, 32'd2);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim_a", rd, 32'd2);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim_b", rd, 32'd3);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim_c", rd, 32'd1);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim_d", rd, 32'd0);
        applyStimulus(1, 8'h10, 32'd1, rd);
        applyStimulus(1, 8'h10, 32'd2, rd);
        applyStimulus(1, 8'h10, 32'd3, rd);

        // Threshold equal to priority masks the source without clearing it
        applyStimulus(1, 8'h24, 32'd2, rd);
        applyStimulus(1, 8'h0C, 32'd2, rd);
        pulseSrc(3'b010);
        idle(1);
        checkOutput("thr_irq_masked", {31'b0, irq}, 32'h0);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("thr_claim0", rd, 32'd0);
        applyStimulus(1, 8'h0C, 32'd1, rd);
        idle(1);
        checkOutput("thr_irq", {31'b0, irq}, 32'h1);
        checkOutput("thr_id", {27'b0, irq_id}, 32'd2);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("thr_claim2", rd, 32'd2);
        applyStimulus(1, 8'h10, 32'd2, rd);

        // Level source 3 held high re-pends after complete
        applyStimulus(1, 8'h08, 32'h3, rd);
        irq_src = 3'b100;
        idle(2);
        checkOutput("lvl_id", {27'b0, irq_id}, 32'd3);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("lvl_claim", rd, 32'd3);
        applyStimulus(1, 8'h10, 32'd3, rd);
        idle(2);
        checkOutput("lvl_repend_irq", {31'b0, irq}, 32'h1);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("lvl_pending", rd, 32'h4);
        irq_src = 3'b000;
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("lvl_claim2", rd, 32'd3);
        applyStimulus(1, 8'h10, 32'd3, rd);
        applyStimulus(1, 8'h08, 32'h7, rd);

        // Claim of ID 1 coinciding with a new edge on source 1
        pulseSrc(3'b001);
        idle(1);
        checkOutput("sim_id", {27'b0, irq_id}, 32'd1);
        irq_src = 3'b001;
        applyStimulus(0, 8'h10, 32'h0, rd);
        irq_src = 3'b000;
        checkOutput("sim_claim", rd, 32'd1);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("sim_pending", rd, 32'h0);
        // Complete coinciding with a new edge: the edge is lost
        irq_src = 3'b001;
        applyStimulus(1, 8'h10, 32'd1, rd);
        irq_src = 3'b000;
        idle(1);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("cmp_edge_pending", rd, 32'h0);
        checkOutput("cmp_edge_irq", {31'b0, irq}, 32'h0);

        // Out-of-range complete leaves in_service[1] set
        pulseSrc(3'b010);
        idle(1);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("claim_id2", rd, 32'd2);
        applyStimulus(1, 8'h10, 32'd4, rd);
        pulseSrc(3'b010);
        idle(2);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("cmp4_pending", rd, 32'h0);
        checkOutput("cmp4_irq", {31'b0, irq}, 32'h0);
        applyStimulus(0, 8'h7C, 32'h0, rd);
        checkOutput("unmapped_rd", rd, 32'h0);
        applyStimulus(1, 8'h7C, 32'hFFFF_FFFF, rd);
        applyStimulus(0, 8'h0C, 32'h0, rd);
        checkOutput("unmapped_wr_thr", rd, 32'd1);

        // Reset while in_service=0x2 and irq_o=1
        pulseSrc(3'b001);
        idle(1);
        checkOutput("pre_rst_irq", {31'b0, irq}, 32'h1);
        bus.req  = 1'b1;
        bus.addr = 8'h10;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
        checkOutput("midrst_id", {27'b0, irq_id}, 32'h0);
        idle(1);
        checkOutput("midrst_ack", {31'b0, bus.ack}, 32'h0);
        bus.req = 1'b0;
        #2 rst_n = 1'b1;
        idle(1);
        applyStimulus(0, 8'h00, 32'h0, rd);
        checkOutput("post_pending", rd, 32'h0);
        applyStimulus(0, 8'h04, 32'h0, rd);
        checkOutput("post_enable", rd, 32'h0);
        applyStimulus(0, 8'h08, 32'h0, rd);
        checkOutput("post_edge", rd, 32'h0);
        applyStimulus(0, 8'h0C, 32'h0, rd);
        checkOutput("post_thresh", rd, 32'h0);
        applyStimulus(0, 8'h10, 32'h0, rd);
        checkOutput("post_claim", rd, 32'h0);
        applyStimulus(0, 8'h20, 32'h0, rd);
        checkOutput("post_prio0", rd, 32'h0);
        applyStimulus(0, 8'h24, 32'h0, rd);
        checkOutput("post_prio1", rd, 32'h0);
        applyStimulus(0, 8'h28, 32'h0, rd);
        checkOutput("post_prio2", rd, 32'h0);
        checkOutput("post_irq", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
